// File: rtl/sudoku_pkg.sv
// Shared definitions for the parametrised Sudoku cell: opcodes, state
// encoding and digit/one-hot helpers sized for the largest puzzle (N=16).
package sudoku_pkg;

    localparam int unsigned MAX_N  = 16;
    localparam int unsigned MAX_VW = 5;

    localparam logic [3:0] CMD_LOAD    = 4'd0;
    localparam logic [3:0] CMD_READ    = 4'd1;
    localparam logic [3:0] CMD_ELIM    = 4'd2;
    localparam logic [3:0] CMD_CLEAR   = 4'd3;
    localparam logic [3:0] CMD_SAVE    = 4'd5;
    localparam logic [3:0] CMD_RESTORE = 4'd6;

    localparam int unsigned ST_W = 2;
    localparam logic [1:0] ST_UNSOLVED = 2'd0;
    localparam logic [1:0] ST_RESOLVE  = 2'd1;
    localparam logic [1:0] ST_SOLVED   = 2'd2;
    localparam logic [1:0] ST_CONFLICT = 2'd3;

    // Digit of the highest set bit (1-based); 0 for an empty mask.
    function automatic logic [MAX_VW-1:0] onehot_to_digit(input logic [MAX_N-1:0] m);
        logic [MAX_VW-1:0] d;
        d = '0;
        for (int i = 0; i < int'(MAX_N); i++) begin
            if (m[i]) d = MAX_VW'(i + 1);
        end
        return d;
    endfunction

    // One-hot mask for digit d; digit 0 maps to an empty mask.
    function automatic logic [MAX_N-1:0] digit_to_onehot(input logic [MAX_VW-1:0] d);
        if (d == '0) return '0;
        return MAX_N'(1) << (d - MAX_VW'(1));
    endfunction

    // True when exactly one bit of the mask is set.
    function automatic logic popcount_is_one(input logic [MAX_N-1:0] m);
        return (m != '0) && ((m & (m - MAX_N'(1))) == '0);
    endfunction

endpackage

// File: rtl/sudoku_cell_stack.sv
// Small LIFO holding cell snapshots; pointer saturates at 0 and DEPTH.
module sudoku_cell_stack #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data_c,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_n;

    // Next pointer: push and pop are ignored at the full/empty limits.
    always_comb begin
        ptr_n = ptr;
        if (push && !full)       ptr_n = ptr + PW'(1);
        else if (pop && !empty)  ptr_n = ptr - PW'(1);
    end

    // Pointer and registered full/empty flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            ptr   <= ptr_n;
            empty <= (ptr_n == '0);
            full  <= (ptr_n == PW'(DEPTH));
        end
    end

    // Snapshot storage; contents need no reset since the pointer guards reads.
    always_ff @(posedge clk) begin
        if (push && !full) mem[AW'(ptr)] <= wr_data;
    end

    assign rd_data_c = empty ? '0 : mem[AW'(ptr - PW'(1))];

endmodule

// File: rtl/sudoku_cell_p.sv
// Parametrised Sudoku cell: value + candidate mask, elimination, auto-resolve
// and conflict detection. Define SUDOKU_CELL_STACK_EN to add the snapshot
// stack used by SAVE/RESTORE; otherwise those opcodes are rejected.
module sudoku_cell_p
    import sudoku_pkg::*;
#(
    parameter int unsigned N     = 9,
    parameter int unsigned VW    = $clog2(N + 1),
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    cmd,
    input  logic [VW-1:0] data_in,
    input  logic          data_in_rdy,
    output logic [VW-1:0] data_out,
    output logic          data_out_valid,
    output logic [VW-1:0] value,
    output logic [N-1:0]  candidates,
    output logic          is_solved,
    output logic          conflict,
    output logic          cmd_err,
    output logic          stack_empty,
    output logic          stack_full
);

    localparam int unsigned  SW       = VW + N + ST_W;
    localparam logic [N-1:0] ALL_ONES = '1;
    localparam logic [VW-1:0] MAX_D   = VW'(N);

    if (!(N == 4 || N == 9 || N == 16) || DEPTH < 1) begin : g_bad_param
        $error("sudoku_cell_p: illegal N or DEPTH");
    end

    logic [1:0]    state, state_n;
    logic [VW-1:0] value_n, data_out_n;
    logic [N-1:0]  cand_n;
    logic          dov_n, err_n;

    logic [N-1:0]  elim_bit, cand_left;
    logic          digit_ok;

    assign digit_ok  = (data_in != '0) && (data_in <= MAX_D);
    assign elim_bit  = N'(digit_to_onehot(MAX_VW'(data_in)));
    assign cand_left = candidates & ~elim_bit;

`ifdef SUDOKU_CELL_STACK_EN
    logic          push, pop;
    logic [SW-1:0] pop_data;

    sudoku_cell_stack #(.W(SW), .DEPTH(DEPTH)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wr_data   ({value, candidates, state}),
        .rd_data_c (pop_data),
        .full      (stack_full),
        .empty     (stack_empty)
    );
`else
    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
`endif

    // Next-state/output decode; listed commands override the auto-resolve.
    always_comb begin
        state_n    = state;
        value_n    = value;
        cand_n     = candidates;
        data_out_n = data_out;
        dov_n      = 1'b0;
        err_n      = 1'b0;
`ifdef SUDOKU_CELL_STACK_EN
        push       = 1'b0;
        pop        = 1'b0;
`endif
        if (state == ST_RESOLVE) begin
            value_n = VW'(onehot_to_digit(MAX_N'(candidates)));
            state_n = ST_SOLVED;
        end
        if (data_in_rdy) begin
            case (cmd)
                CMD_LOAD: begin
                    if (digit_ok) begin
                        value_n = data_in;
                        cand_n  = elim_bit;
                        state_n = ST_SOLVED;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                CMD_READ: begin
                    data_out_n = value;
                    dov_n      = 1'b1;
                end
                CMD_ELIM: begin
                    if (!digit_ok) begin
                        err_n = 1'b1;
                    end else begin
                        case (state)
                            ST_UNSOLVED: begin
                                cand_n = cand_left;
                                if (cand_left == '0)
                                    state_n = ST_CONFLICT;
                                else if (popcount_is_one(MAX_N'(cand_left)))
                                    state_n = ST_RESOLVE;
                            end
                            ST_RESOLVE: begin
                                value_n = value;
                                state_n = ST_RESOLVE;
                                if (cand_left == '0) begin
                                    cand_n  = '0;
                                    state_n = ST_CONFLICT;
                                end
                            end
                            ST_SOLVED: begin
                                if (data_in == value) begin
                                    cand_n  = cand_left;
                                    state_n = ST_CONFLICT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CMD_CLEAR: begin
                    value_n = '0;
                    cand_n  = ALL_ONES;
                    state_n = ST_UNSOLVED;
                end
                CMD_SAVE: begin
`ifdef SUDOKU_CELL_STACK_EN
                    if (stack_full) err_n = 1'b1;
                    else            push  = 1'b1;
`else
                    err_n = 1'b1;
`endif
                end
                CMD_RESTORE: begin
`ifdef SUDOKU_CELL_STACK_EN
                    if (stack_empty) begin
                        err_n = 1'b1;
                    end else begin
                        pop = 1'b1;
                        {value_n, cand_n, state_n} = pop_data;
                    end
`else
                    err_n = 1'b1;
`endif
                end
                default: err_n = 1'b1;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_UNSOLVED;
            value          <= '0;
            candidates     <= ALL_ONES;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            cmd_err        <= 1'b0;
            is_solved      <= 1'b0;
            conflict       <= 1'b0;
        end else begin
            state          <= state_n;
            value          <= value_n;
            candidates     <= cand_n;
            data_out       <= data_out_n;
            data_out_valid <= dov_n;
            cmd_err        <= err_n;
            is_solved      <= (state_n == ST_SOLVED);
            conflict       <= (state_n == ST_CONFLICT);
        end
    end

endmodule

// File: tb/tb_sudoku_cell_p.sv
// Bench for sudoku_cell_p: a 9x9 cell (DEPTH=2) and a 4x4 cell on one clock.
module tb_sudoku_cell_p;
    import sudoku_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 9-digit cell
    logic [3:0] cmd = '0, data_in = '0, data_out, value;
    logic       data_in_rdy = 1'b0, data_out_valid, is_solved, conflict, cmd_err;
    logic       stack_empty, stack_full;
    logic [8:0] candidates;

    // 4-digit cell
    logic [3:0] cmd4 = '0, cand4;
    logic [2:0] din4 = '0, dout4, value4;
    logic       rdy4 = 1'b0, dov4, solved4, conflict4, err4, sempty4, sfull4;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    sudoku_cell_p #(.N(9), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .data_in(data_in), .data_in_rdy(data_in_rdy),
        .data_out(data_out), .data_out_valid(data_out_valid), .value(value),
        .candidates(candidates), .is_solved(is_solved), .conflict(conflict),
        .cmd_err(cmd_err), .stack_empty(stack_empty), .stack_full(stack_full)
    );

    sudoku_cell_p #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .cmd(cmd4), .data_in(din4), .data_in_rdy(rdy4),
        .data_out(dout4), .data_out_valid(dov4), .value(value4),
        .candidates(cand4), .is_solved(solved4), .conflict(conflict4),
        .cmd_err(err4), .stack_empty(sempty4), .stack_full(sfull4)
    );

    // One strobe on the 9-digit cell; returns at the negedge after the edge.
    task automatic send(input logic [3:0] c, input logic [3:0] d);
        cmd = c; data_in = d; data_in_rdy = 1'b1;
        @(negedge clk);
        data_in_rdy = 1'b0;
    endtask

    task automatic send4(input logic [3:0] c, input logic [2:0] d);
        cmd4 = c; din4 = d; rdy4 = 1'b1;
        @(negedge clk);
        rdy4 = 1'b0;
    endtask

    // READ with scoreboard: expectation queued at issue, popped on valid.
    task automatic do_read(input logic [3:0] expv, input string tag);
        int waited;
        logic [3:0] want;
        exp_q.push_back(expv);
        send(CMD_READ, 4'd0);
        waited = 0;
        while (!data_out_valid && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        want = exp_q.pop_front();
        total++;
        if (!data_out_valid) begin
            bad++;
            $display("FAIL %s_valid: data_out_valid never rose, want value %0d", tag, want);
        end else if (data_out !== want) begin
            bad++;
            $display("FAIL %s_data: got %0d want %0d", tag, data_out, want);
        end
        @(negedge clk);
        total++;
        if (data_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_pulse: data_out_valid=%b want 0", tag, data_out_valid);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({value, candidates, is_solved, conflict, cmd_err, data_out_valid} !== {4'd0, 9'h1FF, 4'b0000}) begin
            bad++;
            $display("FAIL reset_outputs: got v=%0d c=%h s=%b k=%b e=%b dv=%b want v=0 c=1ff flags 0",
                     value, candidates, is_solved, conflict, cmd_err, data_out_valid);
        end
        total++;
        if ({stack_empty, stack_full} !== 2'b10) begin
            bad++;
            $display("FAIL reset_stack: got empty=%b full=%b want 1 0", stack_empty, stack_full);
        end
        do_read(4'd0, "reset_read");
    endtask

    task automatic test_load_elim();
        send(CMD_LOAD, 4'd7);
        total++;
        if ({value, candidates, is_solved} !== {4'd7, 9'h040, 1'b1}) begin
            bad++;
            $display("FAIL load7: got v=%0d c=%h s=%b want v=7 c=040 s=1", value, candidates, is_solved);
        end
        do_read(4'd7, "load_read");
        send(CMD_ELIM, 4'd7);
        total++;
        if ({conflict, is_solved, value} !== {1'b1, 1'b0, 4'd7}) begin
            bad++;
            $display("FAIL elim_solved: got k=%b s=%b v=%0d want k=1 s=0 v=7", conflict, is_solved, value);
        end
    endtask

    task automatic test_resolve();
        send(CMD_CLEAR, 4'd0);
        total++;
        if ({value, candidates, conflict} !== {4'd0, 9'h1FF, 1'b0}) begin
            bad++;
            $display("FAIL clear: got v=%0d c=%h k=%b want v=0 c=1ff k=0", value, candidates, conflict);
        end
        for (int d = 1; d <= 8; d++) send(CMD_ELIM, 4'(d));
        total++;
        if ({candidates, value, is_solved} !== {9'h100, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL resolve_state: got c=%h v=%0d s=%b want c=100 v=0 s=0", candidates, value, is_solved);
        end
        @(negedge clk);
        total++;
        if ({value, is_solved, candidates} !== {4'd9, 1'b1, 9'h100}) begin
            bad++;
            $display("FAIL auto_resolve: got v=%0d s=%b c=%h want v=9 s=1 c=100", value, is_solved, candidates);
        end
    endtask

    task automatic test_cmd_err();
        logic [3:0] bad_cmd [4];
        logic [3:0] bad_dat [4];
        bad_cmd[0] = CMD_LOAD; bad_dat[0] = 4'd0;
        bad_cmd[1] = CMD_LOAD; bad_dat[1] = 4'd10;
        bad_cmd[2] = CMD_ELIM; bad_dat[2] = 4'd0;
        bad_cmd[3] = 4'd15;    bad_dat[3] = 4'd3;
        for (int i = 0; i < 4; i++) begin
            send(bad_cmd[i], bad_dat[i]);
            total++;
            if ({cmd_err, value, candidates, is_solved} !== {1'b1, 4'd9, 9'h100, 1'b1}) begin
                bad++;
                $display("FAIL cmd_err_%0d: got e=%b v=%0d c=%h s=%b want e=1 v=9 c=100 s=1",
                         i, cmd_err, value, candidates, is_solved);
            end
            @(negedge clk);
            total++;
            if (cmd_err !== 1'b0) begin
                bad++;
                $display("FAIL cmd_err_pulse_%0d: got %b want 0", i, cmd_err);
            end
        end
    endtask

    task automatic test_stack();
`ifdef SUDOKU_CELL_STACK_EN
        send(CMD_CLEAR, 4'd0);
        send(CMD_ELIM, 4'd3);
        send(CMD_SAVE, 4'd0);
        send(CMD_LOAD, 4'd5);
        send(CMD_SAVE, 4'd0);
        total++;
        if ({stack_full, cmd_err} !== 2'b10) begin
            bad++;
            $display("FAIL stack_two: got full=%b err=%b want 1 0", stack_full, cmd_err);
        end
        send(CMD_SAVE, 4'd0);
        total++;
        if ({cmd_err, stack_full} !== 2'b11) begin
            bad++;
            $display("FAIL save_full: got err=%b full=%b want 1 1", cmd_err, stack_full);
        end
        send(CMD_RESTORE, 4'd0);
        total++;
        if ({value, is_solved} !== {4'd5, 1'b1}) begin
            bad++;
            $display("FAIL restore1: got v=%0d s=%b want v=5 s=1", value, is_solved);
        end
        send(CMD_RESTORE, 4'd0);
        total++;
        if ({value, candidates, stack_empty} !== {4'd0, 9'h1FB, 1'b1}) begin
            bad++;
            $display("FAIL restore2: got v=%0d c=%h empty=%b want v=0 c=1fb empty=1", value, candidates, stack_empty);
        end
        send(CMD_RESTORE, 4'd0);
        total++;
        if ({cmd_err, stack_empty, value, candidates} !== {1'b1, 1'b1, 4'd0, 9'h1FB}) begin
            bad++;
            $display("FAIL restore_empty: got e=%b empty=%b v=%0d c=%h want e=1 empty=1 v=0 c=1fb",
                     cmd_err, stack_empty, value, candidates);
        end
`else
        send(CMD_SAVE, 4'd0);
        total++;
        if ({cmd_err, stack_empty, stack_full} !== 3'b110) begin
            bad++;
            $display("FAIL save_nostack: got e=%b empty=%b full=%b want 1 1 0", cmd_err, stack_empty, stack_full);
        end
        send(CMD_RESTORE, 4'd0);
        total++;
        if ({cmd_err, value, candidates} !== {1'b1, 4'd9, 9'h100}) begin
            bad++;
            $display("FAIL restore_nostack: got e=%b v=%0d c=%h want e=1 v=9 c=100", cmd_err, value, candidates);
        end
`endif
    endtask

    task automatic test_n4_resolve_and_reset();
        send4(CMD_ELIM, 3'd1);
        send4(CMD_ELIM, 3'd2);
        send4(CMD_ELIM, 3'd3);
        total++;
        if ({cand4, value4, solved4} !== {4'b1000, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL n4_resolve_state: got c=%h v=%0d s=%b want c=8 v=0 s=0", cand4, value4, solved4);
        end
        @(negedge clk);
        total++;
        if ({value4, solved4} !== {3'd4, 1'b1}) begin
            bad++;
            $display("FAIL n4_auto_resolve: got v=%0d s=%b want v=4 s=1", value4, solved4);
        end
        send4(CMD_CLEAR, 3'd0);
        send4(CMD_ELIM, 3'd1);
        send4(CMD_ELIM, 3'd2);
        send4(CMD_ELIM, 3'd3);
        // Reset lands during RESOLVE with a LOAD on the bus.
        cmd4 = CMD_LOAD; din4 = 3'd2; rdy4 = 1'b1;
        rst = 1'b1;
        #1;
        total++;
        if ({value4, cand4, solved4, conflict4, err4, dov4} !== {3'd0, 4'hF, 4'b0000}) begin
            bad++;
            $display("FAIL n4_async_reset: got v=%0d c=%h s=%b k=%b e=%b dv=%b want v=0 c=f flags 0",
                     value4, cand4, solved4, conflict4, err4, dov4);
        end
        @(negedge clk);
        rdy4 = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        total++;
        if ({value4, cand4, solved4} !== {3'd0, 4'hF, 1'b0}) begin
            bad++;
            $display("FAIL n4_after_reset: got v=%0d c=%h s=%b want v=0 c=f s=0", value4, cand4, solved4);
        end
        total++;
        if ({value, candidates, stack_empty, stack_full} !== {4'd0, 9'h1FF, 2'b10}) begin
            bad++;
            $display("FAIL n9_after_reset: got v=%0d c=%h empty=%b full=%b want v=0 c=1ff 1 0",
                     value, candidates, stack_empty, stack_full);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_elim();
        test_resolve();
        test_cmd_err();
        test_stack();
        test_n4_resolve_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
